arb_mux: RTL

Parametrised round-robin arbitrating multiplexer with valid/ready handshakes. It merges `CHANNELS` producer streams onto one registered output stream, with per-channel packet locking. It generalises the fixed-width select-driven muxes: selection is decided by the block itself through fair arbitration rather than by an external `sel`. It sits in front of shared consumers such as the memory/bus write path and register-file write port.

---
 rtl/arb_mux_if.sv | 56 +++++
 rtl/arb_mux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_if
// Description : Handshake bundle for arb_mux. Carries the CHANNELS producer
//               streams (valid/data/last/ready) and the single merged
//               consumer stream (valid/data/last/chan/ready).
//               slave  : the arbitrating mux itself.
//               master : the environment (producers plus consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface arb_mux_if #(
  parameter int CHANNELS  = 4,
  parameter int DATA_BITS = 8,
  parameter int CHAN_BITS = $clog2(CHANNELS)
);

  // Producer side
  logic [CHANNELS-1:0]           in_valid;
  logic [CHANNELS*DATA_BITS-1:0] in_data;
  logic [CHANNELS-1:0]           in_last;
  logic [CHANNELS-1:0]           in_ready;

  // Consumer side
  logic                          out_valid;
  logic [DATA_BITS-1:0]          out_data;
  logic                          out_last;
  logic [CHAN_BITS-1:0]          out_chan;
  logic                          out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_chan,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_chan,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux
// Description : Round-robin arbitrating multiplexer. Merges CHANNELS
//               valid/ready producer streams onto one registered output
//               stream. Once a channel wins with a non-last beat it keeps the
//               grant until its last beat transfers (packet lock). The output
//               register loads and unloads in the same cycle, so a stream
//               moves at one beat per clock while out_ready is high.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux #(
  parameter int CHANNELS  = 4,
  parameter int DATA_BITS = 8,
  parameter int CHAN_BITS = $clog2(CHANNELS)
) (
  input  wire logic clk,
  input  wire logic reset,
  arb_mux_if.slave  bus
);

  // Channel count as a (CHAN_BITS+1)-bit value so the rotating scan index
  // can exceed CHANNELS-1 before it is wrapped.
  localparam logic [CHAN_BITS:0]   C_NUM_CHAN  = (CHAN_BITS+1)'(CHANNELS);
  localparam logic [CHAN_BITS-1:0] C_LAST_CHAN = CHAN_BITS'(CHANNELS-1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q,  out_data_d;
  logic                 out_last_q,  out_last_d;
  logic [CHAN_BITS-1:0] out_chan_q,  out_chan_d;
  logic [CHAN_BITS-1:0] prio_ptr_q,  prio_ptr_d;
  logic                 locked_q,    locked_d;
  logic [CHAN_BITS-1:0] lock_chan_q, lock_chan_d;

  // --------------------------------------------------------------------------
  // Combinational decision signals
  // --------------------------------------------------------------------------
  logic                 can_load;
  logic                 cand_found;
  logic [CHAN_BITS-1:0] cand_idx;
  logic [CHANNELS-1:0]  grant_ready;
  logic                 xfer;
  logic [DATA_BITS-1:0] sel_data;
  logic                 sel_last;
  logic [CHAN_BITS-1:0] next_ptr;

  // The output register may take a new beat when empty or being drained now.
  assign can_load = !out_valid_q || bus.out_ready;

  // Pick the candidate: the locked channel, else the first valid channel at or
  // after prio_ptr. The scan runs from the farthest position back to prio_ptr
  // so the last match written is the highest-priority one.
  always_comb begin
    logic [CHAN_BITS:0] scan;
    cand_found = 1'b0;
    cand_idx   = '0;
    scan       = '0;
    if (locked_q) begin
      // A locked channel owns the grant even while its valid is low.
      cand_found = 1'b1;
      cand_idx   = lock_chan_q;
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        scan = {1'b0, prio_ptr_q} + (CHAN_BITS+1)'(k);
        if (scan >= C_NUM_CHAN) begin
          scan = scan - C_NUM_CHAN;
        end
        if (bus.in_valid[scan[CHAN_BITS-1:0]]) begin
          cand_found = 1'b1;
          cand_idx   = scan[CHAN_BITS-1:0];
        end
      end
    end
  end

  // One-hot ready to the candidate, suppressed while reset is asserted.
  always_comb begin
    grant_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      grant_ready[i] = !reset && can_load && cand_found &&
                       (cand_idx == CHAN_BITS'(i));
    end
  end

  assign bus.in_ready = grant_ready;
  assign xfer         = |(bus.in_valid & grant_ready);

  // Route the candidate's beat to the output register input.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cand_idx == CHAN_BITS'(i)) begin
        sel_data = bus.in_data[i*DATA_BITS +: DATA_BITS];
        sel_last = bus.in_last[i];
      end
    end
  end

  // Round-robin pointer advances past the winner, wrapping explicitly so a
  // non-power-of-two channel count never points at a missing channel.
  assign next_ptr = (cand_idx == C_LAST_CHAN) ? '0 : cand_idx + 1'b1;

  // Next-state: load on a transfer, empty on an idle load slot, hold on stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    prio_ptr_d  = prio_ptr_q;
    locked_d    = locked_q;
    lock_chan_d = lock_chan_q;
    if (can_load) begin
      if (xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_last_d  = sel_last;
        out_chan_d  = cand_idx;
        if (sel_last) begin
          locked_d   = 1'b0;
          prio_ptr_d = next_ptr;
        end else begin
          locked_d    = 1'b1;
          lock_chan_d = cand_idx;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State register with synchronous reset; reset drops any lock and beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
      prio_ptr_q  <= '0;
      locked_q    <= 1'b0;
      lock_chan_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
      prio_ptr_q  <= prio_ptr_d;
      locked_q    <= locked_d;
      lock_chan_q <= lock_chan_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_chan  = out_chan_q;

  // At most one producer is ever told it is accepted.
  a_ready_onehot: assert property (@(posedge clk) $onehot0(bus.in_ready));

  // The round-robin pointer and lock owner always name a real channel.
  a_ptr_range: assert property (@(posedge clk) disable iff (reset)
    (prio_ptr_q <= C_LAST_CHAN) && (lock_chan_q <= C_LAST_CHAN));

endmodule

`default_nettype wire
